seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Downstream stage of the Pong top level. Takes the packed 8-digit hex score/status word and time-multiplexes it onto the board's shared 7-segment bus.
- Drives segment cathodes `out` and digit anodes `en_out`, both active-low, as fixed by the board.
- Per-slot blanking suppresses ghosting between digits.
- Incoming data is double-buffered and swapped only at a frame boundary, so the display never shows a torn frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz). Legal range is >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot during which all anodes are off. Legal range is 0 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- load  in  1  single-cycle strobe; captures digits_in and mask_in.
- digits_in  in  32  eight hex nibbles; digit k is [4k+3:4k].
- mask_in  in  8  per-digit enable; 1 means the digit is shown.
- out  out  7  segments {g,f,e,d,c,b,a}, active-low.
- en_out  out  8  digit anodes, active-low; bit k selects digit k.
- frame_tick  out  1  one-cycle pulse on the cycle the active buffer may swap.

Behaviour:
- Reset values (Rst=1 at a rising edge):
  - out=7'h7F, en_out=8'hFF, frame_tick=0.
  - Internal state: idx=0, cnt=0, active digits=0, active mask=0, pending buffer=0, pending flag=0.
- Reset mid-operation behaves identically: blank outputs on the next cycle, scan restarts at slot 0.
- Scan counters:
  - If cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1 (3-bit, 7 wraps to 0).
  - Otherwise cnt<=cnt+1.
  - Frame period is 8*REFRESH_DIV cycles.
- Outputs are registered and computed from the pre-update cnt/idx, giving one cycle of latency:
  - blank = (cnt < BLANK_CYCLES) or (active_mask[idx]==0).
  - en_out <= blank ? 8'hFF : ~(8'b1 << idx).
  - out <= blank ? 7'h7F : ~hex2seg(active_digits[4*idx +: 4]).
  - Exactly one en_out bit is low at any time, or none.
- Frame end is the cycle with idx==7 && cnt==REFRESH_DIV-1.
  - frame_tick <= 1 on the following cycle.
  - If pending flag is set on the frame-end cycle: active <= pending and the flag clears.
- Load rules:
  - load=1 writes pending <= {digits_in, mask_in} and sets the pending flag.
  - A second load before the swap overwrites pending; the last load wins.
  - load on the frame-end cycle itself bypasses the pending buffer: the new data goes straight to active and the flag ends up clear.
  - load and Rst together: Rst wins.
- hex2seg, active-high {g..a}, before inversion:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Counter width is clog2(REFRESH_DIV). No arithmetic overflow is possible beyond the defined wraps.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_OFF=7'h7F and EN_OFF=8'hFF;
  - the 16-entry hex-to-segment constant table;
  - the hex2seg function.
- One sub-module, hex_to_seg7: combinational nibble-to-active-low-segment decoder.
- Counters, double buffer and output registers stay in seg7_scan_driver.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1):
- Reset: hold Rst 3 cycles, then release with no load -> out=7'h7F, en_out=8'hFF throughout (active mask is 0); frame_tick pulses every 32 cycles.
- Load and first frame: load digits_in=32'h76543210, mask_in=8'hFF during frame 0 -> frame 0 stays blank. Frame 1, slot 0: en_out=8'hFF for 1 cycle, then 8'hFE with out=7'h40 for 3 cycles. Slot 1: en_out=8'hFD, out=7'h79. Slot 7: en_out=8'h7F, out=7'h78.
- Masking: active mask=8'h02 with digits 32'hFFFFFFA0 -> only slot 1 drives, en_out=8'hFD, out=7'h08 for 3 cycles per frame; all other slots show 8'hFF/7'h7F.
- Tear-free swap: with 32'h88888888 active, load 32'h11111111 at idx=3 -> slots 3..7 still show out=7'h00; the next frame shows out=7'h79 in every slot. A second load (32'hEEEEEEEE) before frame end -> next frame shows 7'h06.
- Boundary load: load 32'hFFFFFFFF exactly on the frame-end cycle -> next frame shows out=7'h0E; the pending flag is clear, so no further swap occurs at the following frame end.
- Reset mid-frame: assert Rst at idx=5, cnt=2 -> next cycle out=7'h7F, en_out=8'hFF; after release, scanning restarts at slot 0 and the display stays blank until a new load swaps in.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, segment table and payload types for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned EN_W       = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DIGITS_W   = NUM_DIGITS * NIB_W;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [EN_W-1:0]  EN_OFF  = 8'hFF;

  // Active-high {g,f,e,d,c,b,a}; entry 0 sits in the least significant slice.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [DIGITS_W-1:0]   digits;
    logic [NUM_DIGITS-1:0] mask;
  } frame_t;

  function automatic logic [SEG_W-1:0] hex2seg(input logic [NIB_W-1:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/display bus between the score formatter and the 7-segment scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic                  load;
  logic [DIGITS_W-1:0]   digits_in;
  logic [NUM_DIGITS-1:0] mask_in;
  logic [SEG_W-1:0]      out;
  logic [EN_W-1:0]       en_out;
  logic                  frame_tick;

  modport master (
    output load, digits_in, mask_in,
    input  out, en_out, frame_tick
  );

  modport slave (
    input  load, digits_in, mask_in,
    output out, en_out, frame_tick
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = ~hex2seg(nib);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes eight hex digits onto a shared active-low 7-segment bus,
// with per-slot blanking and a frame-synchronous double buffer.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  seg7_scan_driver_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  frame_t           active_q;
  frame_t           pend_q;
  logic             pend_valid;

  logic             slot_end_c;
  logic             frame_end_c;
  logic             in_blank_c;
  logic             blank_c;
  logic [NIB_W-1:0] nib_c;
  logic [SEG_W-1:0] seg_c;
  frame_t           load_frame_c;

  always_comb begin
    slot_end_c   = (cnt == CNT_LAST);
    frame_end_c  = slot_end_c && (idx == IDX_LAST);
    load_frame_c = '{digits: bus.digits_in, mask: bus.mask_in};
  end

  // Blank window at the head of each slot; a zero-length window is never active.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    always_comb in_blank_c = 1'b0;
  end else begin : g_blank
    always_comb in_blank_c = (cnt < CNT_W'(BLANK_CYCLES));
  end

  always_comb begin
    blank_c = in_blank_c || !active_q.mask[idx];
    nib_c   = active_q.digits[{idx, 2'b00} +: NIB_W];
  end

  hex_to_seg7 u_dec (
    .nib   (nib_c),
    .seg_c (seg_c)
  );

  // Scan counters
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      cnt <= '0;
      idx <= idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered display outputs, one cycle behind the scan position
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.out        <= SEG_OFF;
      bus.en_out     <= EN_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.out        <= blank_c ? SEG_OFF : seg_c;
      bus.en_out     <= blank_c ? EN_OFF : ~(EN_W'(1) << idx);
      bus.frame_tick <= frame_end_c;
    end
  end

  // Double buffer: a load on the frame-end cycle goes straight to the active copy.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      active_q   <= '0;
      pend_q     <= '0;
      pend_valid <= 1'b0;
    end else if (frame_end_c) begin
      if (bus.load) begin
        active_q <= load_frame_c;
      end else if (pend_valid) begin
        active_q <= pend_q;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_q     <= load_frame_c;
      pend_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-cycle scoreboard plus a vector table.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic clk = 1'b0;
  logic rst;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [7:0] en;
    logic       tick;
  } obs_t;

  typedef struct {
    logic [31:0] digits;
    logic [7:0]  mask;
    int          slot;
    logic [6:0]  seg;
    logic [7:0]  en;
  } vec_t;

  obs_t        exp_q[$];
  obs_t        last;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [6:0]  segn [16];
  int          t;
  logic [31:0] shown_d, q_d;
  logic [7:0]  shown_m, q_m;
  logic        q_v;
  vec_t        vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One clock: drive inputs, predict the post-edge outputs from absolute time, compare.
  task automatic step(input logic r, input logic l, input logic [31:0] d, input logic [7:0] m);
    obs_t e, a;
    int   slot, ph;
    bit   fe, blank;
    @(negedge clk);
    rst           = r;
    bus.load      = l;
    bus.digits_in = d;
    bus.mask_in   = m;
    if (r) begin
      e       = '{seg: 7'h7F, en: 8'hFF, tick: 1'b0};
      t       = 0;
      shown_d = '0; shown_m = '0; q_d = '0; q_m = '0; q_v = 1'b0;
    end else begin
      slot   = (t / DIV) % 8;
      ph     = t % DIV;
      fe     = ((t % FRAME) == FRAME - 1);
      blank  = (ph < BLANK) || !shown_m[slot];
      e.seg  = blank ? 7'h7F : segn[shown_d[4*slot +: 4]];
      e.en   = blank ? 8'hFF : ~(8'(1) << slot);
      e.tick = fe;
      if (fe) begin
        if (l) begin
          shown_d = d; shown_m = m;
        end else if (q_v) begin
          shown_d = q_d; shown_m = q_m;
        end
        q_v = 1'b0;
      end else if (l) begin
        q_d = d; q_m = m; q_v = 1'b1;
      end
      t++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a    = '{seg: bus.out, en: bus.en_out, tick: bus.frame_tick};
    last = a;
    e    = exp_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL sb t=%0d: got seg=%h en=%h tick=%b want seg=%h en=%h tick=%b",
               t, a.seg, a.en, a.tick, e.seg, e.en, e.tick);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0);
  endtask

  // Step idle cycles until the next cycle to execute sits at frame position pos.
  task automatic advance_to(input int pos);
    for (int k = 0; k < 2 * FRAME && (t % FRAME) != pos; k++) idle();
    chk("advance_bound", 32'(t % FRAME), 32'(pos));
  endtask

  task automatic load_at(input logic [31:0] d, input logic [7:0] m);
    step(1'b0, 1'b1, d, m);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, first_tick, lit;

    rst = 1'b1;
    bus.load = 1'b0; bus.digits_in = '0; bus.mask_in = '0;
    segn = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0]  = '{32'h76543210, 8'hFF, 0, 7'h40, 8'hFE};
    vecs[1]  = '{32'h76543210, 8'hFF, 1, 7'h79, 8'hFD};
    vecs[2]  = '{32'h76543210, 8'hFF, 2, 7'h24, 8'hFB};
    vecs[3]  = '{32'h76543210, 8'hFF, 3, 7'h30, 8'hF7};
    vecs[4]  = '{32'h76543210, 8'hFF, 4, 7'h19, 8'hEF};
    vecs[5]  = '{32'h76543210, 8'hFF, 5, 7'h12, 8'hDF};
    vecs[6]  = '{32'h76543210, 8'hFF, 6, 7'h02, 8'hBF};
    vecs[7]  = '{32'h76543210, 8'hFF, 7, 7'h78, 8'h7F};
    vecs[8]  = '{32'hFEDCBA98, 8'hFF, 0, 7'h00, 8'hFE};
    vecs[9]  = '{32'hFEDCBA98, 8'hFF, 1, 7'h10, 8'hFD};
    vecs[10] = '{32'hFEDCBA98, 8'hFF, 2, 7'h08, 8'hFB};
    vecs[11] = '{32'hFEDCBA98, 8'hFF, 3, 7'h03, 8'hF7};
    vecs[12] = '{32'hFEDCBA98, 8'hFF, 4, 7'h46, 8'hEF};
    vecs[13] = '{32'hFEDCBA98, 8'hFF, 5, 7'h21, 8'hDF};
    vecs[14] = '{32'hFEDCBA98, 8'hFF, 6, 7'h06, 8'hBF};
    vecs[15] = '{32'hFEDCBA98, 8'hFF, 7, 7'h0E, 8'h7F};
    vecs[16] = '{32'hFFFFFFA0, 8'h02, 1, 7'h08, 8'hFD};
    vecs[17] = '{32'hFFFFFFA0, 8'h02, 0, 7'h7F, 8'hFF};
    vecs[18] = '{32'hFFFFFFA0, 8'h02, 5, 7'h7F, 8'hFF};

    // Reset held three cycles, then free-running with nothing loaded
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
    chk("rst_seg", 32'(last.seg), 32'h7F);
    chk("rst_en", 32'(last.en), 32'hFF);
    ticks = 0; first_tick = -1; lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      if (last.tick) begin
        ticks++;
        if (first_tick < 0) first_tick = t - 1;
      end
      if (last.en != 8'hFF) lit++;
    end
    chk("tick_count", 32'(ticks), 32'd2);
    chk("first_tick_pos", 32'(first_tick), 32'(FRAME - 1));
    chk("idle_blank", 32'(lit), 32'd0);

    // Vector table: load at frame start, inspect one slot of the following frame
    for (int i = 0; i < 19; i++) begin
      advance_to(0);
      load_at(vecs[i].digits, vecs[i].mask);
      advance_to(0);
      advance_to(vecs[i].slot * DIV + 1);
      idle();
      chk($sformatf("vec%0d_seg", i), 32'(last.seg), 32'(vecs[i].seg));
      chk($sformatf("vec%0d_en", i), 32'(last.en), 32'(vecs[i].en));
    end

    // Tear-free swap: a mid-frame load waits for the frame boundary
    advance_to(0);
    load_at(32'h88888888, 8'hFF);
    advance_to(0);
    advance_to(3 * DIV);
    load_at(32'h11111111, 8'hFF);
    advance_to(5 * DIV + 2);
    idle();
    chk("tear_old", 32'(last.seg), 32'h00);
    advance_to(0);
    advance_to(2 * DIV + 1);
    idle();
    chk("tear_new", 32'(last.seg), 32'h79);
    advance_to(10);
    load_at(32'h11111111, 8'hFF);
    advance_to(20);
    load_at(32'hEEEEEEEE, 8'hFF);
    advance_to(0);
    advance_to(DIV + 1);
    idle();
    chk("last_wins", 32'(last.seg), 32'h06);

    // Load on the frame-end cycle bypasses the pending buffer
    advance_to(FRAME - 1);
    load_at(32'hFFFFFFFF, 8'hFF);
    chk("bnd_tick", 32'(last.tick), 32'd1);
    advance_to(1);
    idle();
    chk("bnd_swap", 32'(last.seg), 32'h0E);
    advance_to(0);
    advance_to(3 * DIV + 2);
    idle();
    chk("bnd_noswap", 32'(last.seg), 32'h0E);

    // Reset mid-frame at idx=5, cnt=2, with a competing load
    advance_to(5 * DIV + 2);
    step(1'b1, 1'b1, 32'h76543210, 8'hFF);
    chk("midrst_seg", 32'(last.seg), 32'h7F);
    chk("midrst_en", 32'(last.en), 32'hFF);
    lit = 0;
    for (int i = 0; i < FRAME + 8; i++) begin
      idle();
      if (last.en != 8'hFF || last.seg != 7'h7F) lit++;
    end
    chk("midrst_blank", 32'(lit), 32'd0);
    advance_to(0);
    load_at(32'h76543210, 8'hFF);
    advance_to(0);
    advance_to(1);
    idle();
    chk("recover_seg", 32'(last.seg), 32'h40);
    chk("recover_en", 32'(last.en), 32'hFE);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
